cpl_payload_packer: RTL and testbench

- Sits upstream of the DMA read controller, between the PCIe RX completion parser and the per-path data FIFOs.
- Takes a 64-bit completion payload stream (two DWs per beat, each DW individually valid). Packs it into 128-bit words with a thermometer DW-enable, tagged with the completion tag.
- Flushes a partial word at the end of every completion, so a dwen other than 4'b1111 always marks a burst boundary downstream.
- Pulses packer_done with the final word of a request.

---
 rtl/drc_pkg.sv | 33 +++
 rtl/dw_accumulator.sv | 63 ++++++
 rtl/cpl_payload_packer.sv | 131 +++++++++++++
 tb/tb_cpl_payload_packer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/drc_pkg.sv
// Shared definitions for the completion payload packer: DW geometry, FSM states
// and the DW-count to thermometer-enable helper.
package drc_pkg;

  localparam int unsigned DW_W    = 32;
  localparam int unsigned IN_DWS  = 2;
  localparam int unsigned OUT_DWS = 4;
  localparam int unsigned IN_W    = DW_W * IN_DWS;
  localparam int unsigned OUT_W   = DW_W * OUT_DWS;
  localparam int unsigned HOLD_W  = DW_W * 3;
  localparam int unsigned CAT_W   = DW_W * 5;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_CPL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Map a DW count (1..4) to its thermometer enable; 0 maps to no enables.
  function automatic logic [OUT_DWS-1:0] cnt_to_dwen(input logic [CNT_W-1:0] i_cnt);
    logic [OUT_DWS-1:0] v_dwen;
    case (i_cnt)
      3'd0:    v_dwen = 4'b0000;
      3'd1:    v_dwen = 4'b0001;
      3'd2:    v_dwen = 4'b0011;
      3'd3:    v_dwen = 4'b0111;
      default: v_dwen = 4'b1111;
    endcase
    return v_dwen;
  endfunction

endpackage

// File: rtl/dw_accumulator.sv
// DW accumulator: holds up to three DWs, appends incoming beats in order and
// exposes the combined (held + new) word plus its DW count.
module dw_accumulator
  import drc_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [IN_W-1:0]    i_data,
  input  logic [1:0]         i_dw_valid,
  output logic [OUT_W-1:0]   o_word_c,
  output logic [CNT_W-1:0]   o_total_c,
  output logic               o_full_c
);

  logic [HOLD_W-1:0] r_held;
  logic [1:0]        r_fill;

  logic [1:0]        w_n;
  logic [IN_W-1:0]   w_beat;
  logic [CAT_W-1:0]  w_cat;

  // Compact the valid DWs of the beat to the low end; DW0 precedes DW1.
  always_comb begin
    w_n    = 2'b00;
    w_beat = '0;
    if (i_push) begin
      w_n = 2'(i_dw_valid[0]) + 2'(i_dw_valid[1]);
      case (i_dw_valid)
        2'b11:   w_beat = i_data;
        2'b01:   w_beat = IN_W'(i_data[DW_W-1:0]);
        2'b10:   w_beat = IN_W'(i_data[IN_W-1:DW_W]);
        default: w_beat = '0;
      endcase
    end
  end

  // Held DWs are kept zero above the fill, so OR-ing in the shifted beat is safe.
  assign w_cat     = CAT_W'(r_held) | (CAT_W'(w_beat) << {r_fill, 5'b00000});
  assign o_total_c = CNT_W'(r_fill) + CNT_W'(w_n);
  assign o_full_c  = (o_total_c >= CNT_W'(OUT_DWS));
  assign o_word_c  = w_cat[OUT_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_held <= '0;
      r_fill <= 2'd0;
    end else if (i_pop) begin
      if (o_full_c) begin
        r_held <= HOLD_W'(w_cat[CAT_W-1:OUT_W]);
        r_fill <= 2'(o_total_c - CNT_W'(OUT_DWS));
      end else begin
        r_held <= '0;
        r_fill <= 2'd0;
      end
    end else if (i_push) begin
      r_held <= w_cat[HOLD_W-1:0];
      r_fill <= 2'(o_total_c);
    end
  end

endmodule

// File: rtl/cpl_payload_packer.sv
// Packs a 64-bit completion payload stream into 128-bit DW-enabled words,
// flushing partial words at every completion end and flagging request completion.
module cpl_payload_packer
  import drc_pkg::*;
#(
  parameter int unsigned P_TAG_W  = 8,
  parameter bit          P_STRICT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  input  logic [1:0]         s_dw_valid,
  input  logic               s_sop,
  input  logic               s_eop,
  input  logic [P_TAG_W-1:0] s_tag,
  input  logic               s_last_cpl,
  output logic [P_TAG_W-1:0] packer_tag,
  output logic [OUT_W-1:0]   packer_dout,
  output logic [OUT_DWS-1:0] packer_dout_dwen,
  output logic               packer_valid,
  output logic               packer_done,
  output logic               o_proto_err
);

  state_t             r_state;
  logic [P_TAG_W-1:0] r_tag;
  logic               r_last;

  logic               w_fire;
  logic               w_err;
  logic               w_acc;
  logic               w_last;
  logic [P_TAG_W-1:0] w_tag;
  state_t             w_nxt;
  logic               w_emit;
  logic               w_pop;
  logic               w_done;
  logic [OUT_DWS-1:0] w_dwen;
  logic [OUT_W-1:0]   w_word;
  logic [CNT_W-1:0]   w_total;
  logic               w_full;

  dw_accumulator u_acc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_acc),
    .i_pop      (w_pop),
    .i_data     (s_data),
    .i_dw_valid (s_dw_valid),
    .o_word_c   (w_word),
    .o_total_c  (w_total),
    .o_full_c   (w_full)
  );

  // Beat qualification: protocol violations are dropped without touching state.
  always_comb begin
    w_fire = s_valid && s_ready;
    w_err  = P_STRICT && w_fire &&
             (!s_dw_valid[0] ||
              (r_state == IDLE   && !s_sop) ||
              (r_state == IN_CPL &&  s_sop));
    w_acc  = w_fire && !w_err && (r_state != FLUSH);
    w_last = (w_acc && s_sop) ? s_last_cpl : r_last;
    w_tag  = (w_acc && s_sop) ? s_tag      : r_tag;
  end

  // Next-state and word-emission decisions.
  always_comb begin
    w_nxt  = r_state;
    w_emit = 1'b0;
    w_pop  = 1'b0;
    w_done = 1'b0;
    w_dwen = 4'b1111;
    if (r_state == FLUSH) begin
      w_emit = 1'b1;
      w_pop  = 1'b1;
      w_dwen = cnt_to_dwen(w_total);
      w_done = r_last;
      w_nxt  = IDLE;
    end else if (w_acc) begin
      if (s_eop) begin
        w_emit = 1'b1;
        w_pop  = 1'b1;
        if (w_total > CNT_W'(OUT_DWS)) begin
          w_nxt = FLUSH;
        end else begin
          w_dwen = cnt_to_dwen(w_total);
          w_done = w_last;
          w_nxt  = IDLE;
        end
      end else begin
        w_nxt = IN_CPL;
        if (w_full) begin
          w_emit = 1'b1;
          w_pop  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_tag            <= '0;
      r_last           <= 1'b0;
      s_ready          <= 1'b1;
      packer_tag       <= '0;
      packer_dout      <= '0;
      packer_dout_dwen <= '0;
      packer_valid     <= 1'b0;
      packer_done      <= 1'b0;
      o_proto_err      <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      s_ready      <= (w_nxt != FLUSH);
      r_tag        <= w_tag;
      r_last       <= w_last;
      packer_valid <= w_emit;
      packer_done  <= w_done;
      o_proto_err  <= o_proto_err | w_err;
      if (w_emit) begin
        packer_tag       <= w_tag;
        packer_dout      <= w_word;
        packer_dout_dwen <= w_dwen;
      end
    end
  end

endmodule

// File: tb/tb_cpl_payload_packer.sv
// Scoreboard bench for cpl_payload_packer: directed completions push expected
// words into a queue, a negedge monitor pops and compares every output word.
module tb_cpl_payload_packer;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic [1:0]   s_dw_valid;
  logic         s_sop;
  logic         s_eop;
  logic [7:0]   s_tag;
  logic         s_last_cpl;
  logic [7:0]   packer_tag;
  logic [127:0] packer_dout;
  logic [3:0]   packer_dout_dwen;
  logic         packer_valid;
  logic         packer_done;
  logic         o_proto_err;

  typedef struct {
    logic [7:0]   tag;
    logic [127:0] dout;
    logic [3:0]   dwen;
    logic         done;
  } exp_t;

  exp_t q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   last_wait = 0;

  always #5 i_clk = ~i_clk;

  cpl_payload_packer #(.P_TAG_W(8), .P_STRICT(1'b1)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .s_dw_valid       (s_dw_valid),
    .s_sop            (s_sop),
    .s_eop            (s_eop),
    .s_tag            (s_tag),
    .s_last_cpl       (s_last_cpl),
    .packer_tag       (packer_tag),
    .packer_dout      (packer_dout),
    .packer_dout_dwen (packer_dout_dwen),
    .packer_valid     (packer_valid),
    .packer_done      (packer_done),
    .o_proto_err      (o_proto_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] w4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic expect_word(input logic [7:0] tag, input logic [127:0] dout,
                             input logic [3:0] dwen, input logic done);
    exp_t e;
    e.tag = tag; e.dout = dout; e.dwen = dwen; e.done = done;
    q.push_back(e);
  endtask

  // Present one beat and hold it until accepted; leaves s_valid high for back-to-back.
  task automatic beat(input logic sop, input logic eop, input logic [1:0] dwv,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [7:0] tag, input logic last);
    int w;
    s_valid = 1'b1; s_sop = sop; s_eop = eop; s_dw_valid = dwv;
    s_data = {d1, d0}; s_tag = tag; s_last_cpl = last;
    w = 0;
    while (!s_ready && w < 20) begin
      @(posedge i_clk); #1;
      w++;
    end
    last_wait = w;
    if (!s_ready) begin
      n_checks++;
      $display("FAIL beat_timeout: s_ready still %b after %0d cycles, required 1", s_ready, w);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic check_reset_state(input string tagname);
    chk({tagname, "_valid"}, 128'(packer_valid), 128'd0);
    chk({tagname, "_done"},  128'(packer_done),  128'd0);
    chk({tagname, "_dout"},  packer_dout,        128'd0);
    chk({tagname, "_dwen"},  128'(packer_dout_dwen), 128'd0);
    chk({tagname, "_tag"},   128'(packer_tag),   128'd0);
    chk({tagname, "_err"},   128'(o_proto_err),  128'd0);
    chk({tagname, "_ready"}, 128'(s_ready),      128'd1);
    chk({tagname, "_fill"},  128'(dut.u_acc.r_fill), 128'd0);
  endtask

  // Monitor: every presented word must match the head of the scoreboard queue.
  always @(negedge i_clk) begin
    if (!i_rst && packer_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got tag %h dout %h dwen %b, required no word",
                 packer_tag, packer_dout, packer_dout_dwen);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word_dout", packer_dout, e.dout);
        chk("word_tag_dwen_done", 128'({packer_tag, packer_dout_dwen, packer_done}),
            128'({e.tag, e.dwen, e.done}));
      end
    end else if (!i_rst && packer_done) begin
      n_checks++;
      $display("FAIL done_without_valid: got done 1 valid 0, required done 0");
    end
  end

  initial begin
    i_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_dw_valid = 2'b00;
    s_sop = 1'b0; s_eop = 1'b0; s_tag = '0; s_last_cpl = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    check_reset_state("rst");
    i_rst = 1'b0;
    idle(1);

    // Single-beat completion, one DW, final of request
    expect_word(8'h05, w4(32'hA, 0, 0, 0), 4'b0001, 1'b1);
    beat(1, 1, 2'b01, 32'hA, 32'h0, 8'h05, 1'b1);
    idle(2);

    // Eight DWs in four two-DW beats
    expect_word(8'h12, w4(1, 2, 3, 4), 4'b1111, 1'b0);
    expect_word(8'h12, w4(5, 6, 7, 8), 4'b1111, 1'b0);
    beat(1, 0, 2'b11, 1, 2, 8'h12, 1'b0);
    beat(0, 0, 2'b11, 3, 4, 8'h12, 1'b0);
    beat(0, 0, 2'b11, 5, 6, 8'h12, 1'b0);
    beat(0, 1, 2'b11, 7, 8, 8'h12, 1'b0);
    idle(2);

    // Seven DWs: partial tail word, no flush
    expect_word(8'h33, w4(1, 2, 3, 4), 4'b1111, 1'b0);
    expect_word(8'h33, w4(5, 6, 7, 0), 4'b0111, 1'b1);
    beat(1, 0, 2'b11, 1, 2, 8'h33, 1'b1);
    beat(0, 0, 2'b11, 3, 4, 8'h33, 1'b1);
    beat(0, 0, 2'b01, 5, 32'hDEAD, 8'h33, 1'b1);
    beat(0, 1, 2'b11, 6, 7, 8'h33, 1'b1);
    chk("no_flush_ready", 128'(s_ready), 128'd1);
    idle(2);

    // Three held DWs plus a two-DW eop: full word, flush cycle, residue word
    expect_word(8'h44, w4(1, 2, 3, 4), 4'b1111, 1'b0);
    expect_word(8'h44, w4(5, 0, 0, 0), 4'b0001, 1'b1);
    expect_word(8'h45, w4(9, 10, 0, 0), 4'b0011, 1'b0);
    beat(1, 0, 2'b11, 1, 2, 8'h44, 1'b1);
    beat(0, 0, 2'b01, 3, 32'hBAD, 8'h44, 1'b1);
    beat(0, 1, 2'b11, 4, 5, 8'h44, 1'b1);
    chk("flush_ready_low", 128'(s_ready), 128'd0);
    beat(1, 1, 2'b11, 9, 10, 8'h45, 1'b0);
    chk("flush_stall_cycles", 128'(last_wait), 128'd1);
    idle(3);

    // Protocol error: non-sop beat in IDLE with dw_valid 10
    beat(0, 1, 2'b10, 32'h77, 32'h88, 8'h66, 1'b1);
    idle(2);
    chk("proto_err_set", 128'(o_proto_err), 128'd1);

    // Back-to-back completions with different tags
    expect_word(8'h01, w4(1, 2, 3, 0), 4'b0111, 1'b0);
    expect_word(8'h02, w4(4, 0, 0, 0), 4'b0001, 1'b1);
    beat(1, 0, 2'b11, 1, 2, 8'h01, 1'b0);
    beat(0, 1, 2'b01, 3, 32'hF00D, 8'h01, 1'b0);
    beat(1, 1, 2'b01, 4, 32'hCAFE, 8'h02, 1'b1);
    idle(3);
    chk("proto_err_sticky", 128'(o_proto_err), 128'd1);

    // Reset in the middle of a completion, then a clean completion
    beat(1, 0, 2'b11, 32'hDEAD, 32'hBEEF, 8'h77, 1'b1);
    s_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_reset_state("midrst");
    i_rst = 1'b0;
    idle(1);
    expect_word(8'h78, w4(32'h11, 0, 0, 0), 4'b0001, 1'b1);
    beat(1, 1, 2'b01, 32'h11, 32'h22, 8'h78, 1'b1);
    idle(5);

    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
